// File: rtl/conv_layer_sequencer_if.sv
// Control and engine-side signals of the convolution layer sequencer.
// master: controller/engines; slave: the sequencer itself.
interface conv_layer_sequencer_if #(
    parameter int NUM_LAYERS = 3,
    parameter int TMO_W      = 16
);
    logic                  start;
    logic [NUM_LAYERS-1:0] layer_mask;
    logic                  abort;
    logic [TMO_W-1:0]      tmo_cycles;
    logic [NUM_LAYERS-1:0] conv_done;
    logic [NUM_LAYERS-1:0] conv_start;
    logic [NUM_LAYERS-1:0] conv_en;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic                  error;
    logic [1:0]            err_layer;
    logic [1:0]            layers_run;

    modport master (
        output start, layer_mask, abort, tmo_cycles, conv_done,
        input  conv_start, conv_en, busy, done, aborted,
        input  error, err_layer, layers_run
    );

    modport slave (
        input  start, layer_mask, abort, tmo_cycles, conv_done,
        output conv_start, conv_en, busy, done, aborted,
        output error, err_layer, layers_run
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Runs the selected convolution engines in layer order after one start,
// with a per-layer watchdog and done/abort/error status.
module conv_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int TMO_W      = 16
) (
    input logic                   clk,
    input logic                   reset,
    conv_layer_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT, NEXT, FINISH, ERROR
    } state_t;

    state_t                state, state_n;
    logic [NUM_LAYERS-1:0] mask, mask_n;
    logic [1:0]            cur, cur_n;
    logic [1:0]            run, run_n;
    logic [1:0]            err_layer, err_layer_n;
    logic [TMO_W-1:0]      timer, timer_n;
    logic                  error, error_n;
    logic                  aborted, aborted_n;
    logic [1:0]            low_idx, nxt_idx;
    logic                  low_ok, nxt_ok;
    logic [NUM_LAYERS-1:0] sel;

    // Lowest requested layer, and next latched layer above cur
    always_comb begin
        low_ok  = 1'b0;
        low_idx = '0;
        nxt_ok  = 1'b0;
        nxt_idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (bus.layer_mask[i]) begin
                low_ok  = 1'b1;
                low_idx = 2'(i);
            end
            if (mask[i] && i > int'(cur)) begin
                nxt_ok  = 1'b1;
                nxt_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_n     = state;
        mask_n      = mask;
        cur_n       = cur;
        timer_n     = timer;
        run_n       = run;
        error_n     = error;
        err_layer_n = err_layer;
        aborted_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    mask_n      = bus.layer_mask;
                    error_n     = 1'b0;
                    err_layer_n = '0;
                    run_n       = '0;
                    if (low_ok) begin
                        cur_n   = low_idx;
                        state_n = LAUNCH;
                    end else begin
                        state_n = FINISH;
                    end
                end
            end
            LAUNCH: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.conv_done[cur]) begin
                    run_n   = run + 2'd1;
                    state_n = NEXT;
                end else if (bus.tmo_cycles != '0 &&
                             timer == bus.tmo_cycles - TMO_W'(1)) begin
                    state_n = ERROR;
                end else if (timer != '1) begin
                    timer_n = timer + TMO_W'(1);
                end
            end
            NEXT: begin
                if (nxt_ok) begin
                    cur_n   = nxt_idx;
                    state_n = LAUNCH;
                end else begin
                    state_n = FINISH;
                end
            end
            FINISH: state_n = IDLE;
            ERROR: begin
                error_n     = 1'b1;
                err_layer_n = cur;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (bus.abort &&
            (state == LAUNCH || state == WAIT || state == NEXT)) begin
            state_n   = IDLE;
            aborted_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= '0;
            cur       <= '0;
            timer     <= '0;
            run       <= '0;
            error     <= 1'b0;
            err_layer <= '0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            mask      <= mask_n;
            cur       <= cur_n;
            timer     <= timer_n;
            run       <= run_n;
            error     <= error_n;
            err_layer <= err_layer_n;
            aborted   <= aborted_n;
        end
    end

    assign sel            = NUM_LAYERS'(1) << cur;
    assign bus.conv_start = (state == LAUNCH) ? sel : '0;
    assign bus.conv_en    = (state == LAUNCH || state == WAIT) ? sel : '0;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == FINISH);
    assign bus.aborted    = aborted;
    assign bus.error      = error;
    assign bus.err_layer  = err_layer;
    assign bus.layers_run = run;
endmodule
